// File: rtl/im_loadable.sv
// im_loadable: writable instruction memory for the ARM-subset core.
// Holds DEPTH 32-bit words in a synchronous-read array. A byte-serial boot
// loader writes the array, assembling bytes little-endian. After reset a
// hardware walk clears the array.
//
// Ports:
//   clk, rst       system clock, synchronous active-high reset
//   fetch_en       fetch request (serviced in IDLE only)
//   PC_in          byte address of the instruction
//   instruction    registered fetched word (0 on a faulting fetch)
//   instr_valid    a fetch was accepted on the previous edge
//   misaligned     registered: fetched PC had PC_in[1:0] != 0
//   out_of_range   registered: fetched PC had PC_in[31:2] >= DEPTH
//   busy           FSM is not in IDLE (clearing or loading)
//   ld_start       begin a load session at word 0
//   ld_byte_valid  ld_byte is presented
//   ld_byte        program byte
//   ld_last        final byte of the session
//   ld_ready       loader accepts a byte this cycle
//   ld_done        one-cycle pulse when a session finishes
module im_loadable #(
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_en,
    input  logic [31:0] PC_in,
    output logic [31:0] instruction,
    output logic        instr_valid,
    output logic        misaligned,
    output logic        out_of_range,
    output logic        busy,
    input  logic        ld_start,
    input  logic        ld_byte_valid,
    input  logic [7:0]  ld_byte,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        ld_done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_LOAD  = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] clr_idx;
    logic [PW-1:0] ptr;
    logic [1:0]    bcnt;
    logic [23:0]   asm_q;

    logic          accept;
    logic          word_full;
    logic          session_end;
    logic          clear_last;
    logic          fetch_go;
    logic          pc_mis;
    logic          pc_oor;
    logic [AW-1:0] fetch_idx;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   assembled;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        unique case (state)
            ST_CLEAR: if (clear_last)  state_next = ST_IDLE;
            ST_IDLE:  if (ld_start)    state_next = ST_LOAD;
            ST_LOAD:  if (session_end) state_next = ST_IDLE;
            default:                   state_next = ST_CLEAR;
        endcase
    end

    // Current byte merged into the partial word; missing upper bytes read as 0
    always_comb begin
        assembled = '0;
        unique case (bcnt)
            2'd0:    assembled = {24'd0, ld_byte};
            2'd1:    assembled = {16'd0, ld_byte, asm_q[7:0]};
            2'd2:    assembled = {8'd0, ld_byte, asm_q[15:0]};
            default: assembled = {ld_byte, asm_q};
        endcase
    end

    // Output / control decode from state
    always_comb begin
        busy        = (state != ST_IDLE);
        ld_ready    = (state == ST_LOAD) && (ptr < PW'(DEPTH));
        accept      = ld_ready && ld_byte_valid;
        word_full   = accept && (bcnt == 2'd3);
        // Session ends on ld_last, or when the final word of the array fills
        session_end = accept && (ld_last || (word_full && (ptr == PW'(DEPTH - 1))));
        clear_last  = (state == ST_CLEAR) && (clr_idx == AW'(DEPTH - 1));
        fetch_go    = (state == ST_IDLE) && fetch_en;
        pc_mis      = |PC_in[1:0];
        pc_oor      = |PC_in[31:AW+2];
        fetch_idx   = PC_in[AW+1:2];

        mem_we    = 1'b0;
        mem_addr  = clr_idx;
        mem_wdata = '0;
        if (state == ST_CLEAR) begin
            mem_we = 1'b1;
        end else if (accept && (word_full || ld_last)) begin
            mem_we    = 1'b1;
            mem_addr  = ptr[AW-1:0];
            mem_wdata = assembled;
        end
    end

    // Instruction array write port (clear walk or loader)
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem[mem_addr] <= mem_wdata;
        end
    end

    // Clear index, loader pointer, byte count, assembly register, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            clr_idx <= '0;
            ptr     <= '0;
            bcnt    <= '0;
            asm_q   <= '0;
            ld_done <= 1'b0;
        end else begin
            ld_done <= session_end;
            if (state == ST_CLEAR) begin
                clr_idx <= clr_idx + AW'(1);
            end
            if ((state == ST_IDLE) && ld_start) begin
                ptr   <= '0;
                bcnt  <= '0;
                asm_q <= '0;
            end
            if (accept) begin
                bcnt <= bcnt + 2'd1;
                unique case (bcnt)
                    2'd0:    asm_q[7:0]   <= ld_byte;
                    2'd1:    asm_q[15:8]  <= ld_byte;
                    2'd2:    asm_q[23:16] <= ld_byte;
                    default: asm_q        <= '0;
                endcase
                if (word_full) begin
                    ptr <= ptr + PW'(1);
                end
                // A partial final word is already written; drop the leftovers
                if (ld_last) begin
                    bcnt  <= '0;
                    asm_q <= '0;
                end
            end
        end
    end

    // Registered fetch result; held when no fetch is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            instruction  <= '0;
            instr_valid  <= 1'b0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
        end else begin
            instr_valid <= fetch_go;
            if (fetch_go) begin
                misaligned   <= pc_mis;
                out_of_range <= pc_oor;
                instruction  <= (pc_mis || pc_oor) ? 32'd0 : mem[fetch_idx];
            end
        end
    end

endmodule

// File: tb/tb_im_loadable.sv
// tb_im_loadable: self-checking bench for im_loadable (DEPTH = 16).
// A byte-addressed reference model predicts every output each cycle;
// directed tests add literal expectations.
module tb_im_loadable;

    localparam int DEPTH = 16;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic [31:0] PC_in;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        misaligned;
    logic        out_of_range;
    logic        busy;
    logic        ld_start;
    logic        ld_byte_valid;
    logic [7:0]  ld_byte;
    logic        ld_last;
    logic        ld_ready;
    logic        ld_done;

    always #5 clk = ~clk;

    im_loadable #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_en     (fetch_en),
        .PC_in        (PC_in),
        .instruction  (instruction),
        .instr_valid  (instr_valid),
        .misaligned   (misaligned),
        .out_of_range (out_of_range),
        .busy         (busy),
        .ld_start     (ld_start),
        .ld_byte_valid(ld_byte_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .ld_done      (ld_done)
    );

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    bit chk_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory plus a coarse mode
    localparam int M_CLR  = 0;
    localparam int M_IDLE = 1;
    localparam int M_LOAD = 2;

    int          mode;
    int          clr_left;
    int          nb;
    logic [7:0]  mb [4*DEPTH];
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_mis;
    logic        e_oor;
    logic        e_done;

    function automatic logic [31:0] mword(input int w);
        return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mode     = M_CLR;
            clr_left = DEPTH;
            e_instr  = '0;
            e_valid  = 1'b0;
            e_mis    = 1'b0;
            e_oor    = 1'b0;
            e_done   = 1'b0;
        end else begin
            e_valid = 1'b0;
            e_done  = 1'b0;
            case (mode)
                M_CLR: begin
                    clr_left--;
                    if (clr_left == 0) begin
                        for (int i = 0; i < 4*DEPTH; i++) mb[i] = 8'h00;
                        mode = M_IDLE;
                    end
                end
                M_IDLE: begin
                    if (fetch_en) begin
                        e_mis   = (PC_in % 4) != 0;
                        e_oor   = (PC_in >> 2) >= 32'(DEPTH);
                        e_instr = (e_mis || e_oor) ? 32'd0 : mword(int'(PC_in >> 2));
                        e_valid = 1'b1;
                    end
                    if (ld_start) begin
                        mode = M_LOAD;
                        nb   = 0;
                    end
                end
                default: begin
                    if (ld_byte_valid) begin
                        mb[nb] = ld_byte;
                        if (ld_last) begin
                            while ((nb % 4) != 3) begin
                                nb++;
                                mb[nb] = 8'h00;
                            end
                        end
                        nb++;
                        if (ld_last || nb == 4*DEPTH) begin
                            mode   = M_IDLE;
                            e_done = 1'b1;
                        end
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_on) begin
            chk("instruction",  instruction,  e_instr);
            chk("instr_valid",  instr_valid,  e_valid);
            chk("misaligned",   misaligned,   e_mis);
            chk("out_of_range", out_of_range, e_oor);
            chk("busy",         busy,         mode != M_IDLE);
            chk("ld_ready",     ld_ready,     mode == M_LOAD);
            chk("ld_done",      ld_done,      e_done);
            if (ld_done === 1'b1) done_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [31:0] pc);
        fetch_en = 1'b1;
        PC_in    = pc;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic wait_clear(output int cnt);
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            tick();
        end
    endtask

    task automatic load_bytes(input byte_q_t q, input bit use_last,
                              input int fetch_n, output int acc);
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        acc = 0;
        for (int i = 0; i < q.size(); i++) begin
            ld_byte_valid = 1'b1;
            ld_byte       = q[i];
            ld_last       = use_last && (i == q.size() - 1);
            fetch_en      = (i < fetch_n);
            PC_in         = 32'h0;
            if (ld_ready === 1'b1) acc++;
            tick();
        end
        ld_byte_valid = 1'b0;
        ld_last       = 1'b0;
        fetch_en      = 1'b0;
    endtask

    initial begin
        byte_q_t q;
        int cnt;
        int acc;
        int d0;

        rst = 1'b1; fetch_en = 1'b0; PC_in = '0; ld_start = 1'b0;
        ld_byte_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;

        // Reset and clear walk
        tick();
        chk_on = 1'b1;
        chk("rst_instr", instruction, 32'h0);
        chk("rst_ld_ready", ld_ready, 1'b0);
        tick();
        rst = 1'b0;
        wait_clear(cnt);
        chk("clear_cycles", cnt, 16);
        do_fetch(32'h3C);
        chk("fetch_3c_instr", instruction, 32'h0);
        chk("fetch_3c_valid", instr_valid, 1'b1);

        // Word assembly
        d0 = done_cnt;
        q = '{8'h14, 8'h00, 8'hA0, 8'hE3, 8'h01, 8'h1A, 8'hA0, 8'hE3};
        load_bytes(q, 1'b1, 0, acc);
        chk("wa_ld_done", ld_done, 1'b1);
        chk("wa_busy", busy, 1'b0);
        tick();
        chk("wa_done_once", done_cnt - d0, 1);
        do_fetch(32'h0);
        chk("wa_pc0", instruction, 32'hE3A00014);
        do_fetch(32'h4);
        chk("wa_pc4", instruction, 32'hE3A01A01);

        // Partial final word
        q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB};
        load_bytes(q, 1'b1, 0, acc);
        tick();
        do_fetch(32'h0);
        chk("pw_pc0", instruction, 32'h44332211);
        do_fetch(32'h4);
        chk("pw_pc4", instruction, 32'h000000AB);

        // Fetch faults
        do_fetch(32'h6);
        chk("f6_instr", instruction, 32'h0);
        chk("f6_mis", misaligned, 1'b1);
        chk("f6_oor", out_of_range, 1'b0);
        do_fetch(32'h40);
        chk("f40_oor", out_of_range, 1'b1);
        chk("f40_mis", misaligned, 1'b0);
        do_fetch(32'h41);
        chk("f41_mis", misaligned, 1'b1);
        chk("f41_oor", out_of_range, 1'b1);
        do_fetch(32'h0);
        chk("f0_mis", misaligned, 1'b0);
        chk("f0_oor", out_of_range, 1'b0);
        chk("f0_instr", instruction, 32'h44332211);

        // ld_start together with a fetch: old contents returned
        ld_start = 1'b1; fetch_en = 1'b1; PC_in = 32'h0;
        tick();
        ld_start = 1'b0; fetch_en = 1'b0;
        chk("sim_instr", instruction, 32'h44332211);
        chk("sim_busy", busy, 1'b1);
        ld_byte_valid = 1'b1; ld_byte = 8'h5A; ld_last = 1'b1;
        tick();
        ld_byte_valid = 1'b0; ld_last = 1'b0;
        chk("sim_done", ld_done, 1'b1);
        do_fetch(32'h0);
        chk("sim_pc0", instruction, 32'h0000005A);

        // Capacity: 70 bytes offered, 64 accepted
        d0 = done_cnt;
        q = {};
        for (int i = 0; i < 70; i++) q.push_back(8'(i));
        load_bytes(q, 1'b0, 60, acc);
        chk("cap_accepted", acc, 64);
        chk("cap_ready", ld_ready, 1'b0);
        chk("cap_done_once", done_cnt - d0, 1);
        do_fetch(32'h0);
        chk("cap_pc0", instruction, 32'h03020100);
        do_fetch(32'h20);
        chk("cap_pc20", instruction, 32'h23222120);
        do_fetch(32'h3C);
        chk("cap_pc3c", instruction, 32'h3F3E3D3C);

        // Reset in the middle of a session
        d0 = done_cnt;
        q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h12, 8'h34};
        load_bytes(q, 1'b0, 0, acc);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear(cnt);
        chk("rml_clear_cycles", cnt, 16);
        chk("rml_no_done", done_cnt - d0, 0);
        do_fetch(32'h0);
        chk("rml_pc0", instruction, 32'h0);
        do_fetch(32'h4);
        chk("rml_pc4", instruction, 32'h0);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
